reset_sequencer: RTL and testbench

//  Consumes the power-on reset (inverted rst_n of the all-digital PoR generator) and

---
 rtl/reset_sequencer.sv | 113 +++++++++++
 tb/tb_reset_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronises power-on reset deassertion, holds reset
// for a minimum time, then releases STAGES active-low reset outputs in order
// with fixed spacing. Also restarts the release sequence on a software request.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGES      = 4,
    parameter int STAGE_DLY   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    output logic [STAGES-1:0] rst_out_n,
    output logic              ready,
    output logic              sw_rst_ack,
    output logic              rst_cause
);

    // One counter serves both the hold phase and the inter-stage spacing, so it
    // is sized for the larger of the two terminal counts.
    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_DLY) ? HOLD_CYCLES : STAGE_DLY;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_s;
    logic [STAGES-1:0]      rel_next;

    // Deassertion synchroniser: set asynchronously by rst, drains to 0 on clk.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the chain into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_s = sync_q[SYNC_STAGES-1];

    // Next release pattern: shift a 1 in from bit 0, so bits can only be
    // released in ascending order and never return to 0 outside a restart.
    assign rel_next = (rst_out_n << 1) | STAGES'(1);

    // Sequencer FSM with registered outputs; rst clears everything without clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            rst_out_n  <= '0;
            ready      <= 1'b0;
            sw_rst_ack <= 1'b0;
            rst_cause  <= 1'b0;
        end else begin
            sw_rst_ack <= 1'b0;
            if (!rst_s) begin
                case (state)
                    ST_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt       <= '0;
                            rst_out_n <= rel_next;
                            // With a single stage there is nothing left to space out.
                            state     <= (&rel_next) ? ST_RUN : ST_RELEASE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == DLY_LAST) begin
                            cnt       <= '0;
                            rst_out_n <= rel_next;
                            if (&rel_next) begin
                                state <= ST_RUN;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        // Software request is only honoured once fully out of reset;
                        // it restarts at the hold phase without resynchronising.
                        if (sw_rst_req) begin
                            rst_out_n  <= '0;
                            ready      <= 1'b0;
                            sw_rst_ack <= 1'b1;
                            rst_cause  <= 1'b1;
                            cnt        <= '0;
                            state      <= ST_HOLD;
                        end else begin
                            ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: expected output transitions are
// queued with their edge numbers when stimulus is applied and matched against
// every observed change of the DUT outputs.
`timescale 1ns/1ps
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] rst_out_n;
    logic       ready;
    logic       sw_rst_ack;
    logic       rst_cause;

    // Minimal configuration instance
    logic       rst1 = 1'b1;
    logic       sw_rst_req1 = 1'b0;
    logic [0:0] rst_out_n1;
    logic       ready1;
    logic       sw_rst_ack1;
    logic       rst_cause1;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int base;

    typedef struct {
        int         cyc;
        logic [6:0] vec;   // {sw_rst_ack, rst_cause, ready, rst_out_n}
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    logic [6:0] cur;
    logic [6:0] prev;

    reset_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .rst_out_n  (rst_out_n),
        .ready      (ready),
        .sw_rst_ack (sw_rst_ack),
        .rst_cause  (rst_cause)
    );

    reset_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .STAGES      (1),
        .STAGE_DLY   (1)
    ) dut_s1 (
        .clk        (clk),
        .rst        (rst1),
        .sw_rst_req (sw_rst_req1),
        .rst_out_n  (rst_out_n1),
        .ready      (ready1),
        .sw_rst_ack (sw_rst_ack1),
        .rst_cause  (rst_cause1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue the release of nbits stages starting at base+first, optionally ready.
    task automatic push_seq(input int b, input int first, input logic cause,
                            input int nbits, input bit with_ready);
        ev_t e;
        for (int k = 0; k < nbits; k++) begin
            e.cyc = b + first + k * 8;
            e.vec = {1'b0, cause, 1'b0, 4'((1 << (k + 1)) - 1)};
            exp_q.push_back(e);
        end
        if (with_ready) begin
            e.cyc = b + first + 3 * 8 + 1;
            e.vec = {1'b0, cause, 1'b1, 4'hF};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_ev(input int c, input logic [6:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    // Step n edges, sampling on the falling edge and matching output changes.
    task automatic run_window(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cur = {sw_rst_ack, rst_cause, ready, rst_out_n};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", 32'(cur), 32'(prev));
                end else begin
                    ev = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(ev.cyc));
                    check("event_value", 32'(cur), 32'(ev.vec));
                end
                prev = cur;
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                ev = exp_q.pop_front();
                check("missed_event", 32'(cur), 32'(ev.vec));
            end
        end
    endtask

    // Assert rst between edges and confirm the outputs clear without a clock.
    task automatic async_reset();
        rst = 1'b1;
        #2;
        check("async_rst_out_n", 32'(rst_out_n), 32'h0);
        check("async_ready", 32'(ready), 32'h0);
        check("async_ack", 32'(sw_rst_ack), 32'h0);
        check("async_cause", 32'(rst_cause), 32'h0);
        prev = 7'h00;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst  = 1'b0;
        base = cyc;
    endtask

    initial begin
        int d;
        prev = 7'h00;

        // Reset state at time zero
        #1;
        check("reset_rst_out_n", 32'(rst_out_n), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_cause", 32'(rst_cause), 32'h0);
        run_window(3);

        // 1: power-up release timing
        release_rst();
        push_seq(base, 18, 1'b0, 4, 1'b1);
        run_window(48);
        check("t1_pending", 32'(exp_q.size()), 32'h0);

        // 2: rst pulsed at edge 30, then full restart including synchroniser
        async_reset();
        run_window(2);
        release_rst();
        push_seq(base, 18, 1'b0, 2, 1'b0);
        run_window(30);
        async_reset();
        run_window(3);
        release_rst();
        push_seq(base, 18, 1'b0, 4, 1'b1);
        run_window(46);
        check("t2_pending", 32'(exp_q.size()), 32'h0);

        // 3: one-cycle software request while running
        sw_rst_req = 1'b1;
        base = cyc;
        push_ev(base + 1, 7'b11_0_0000);
        push_ev(base + 2, 7'b01_0_0000);
        push_seq(base + 1, 16, 1'b1, 4, 1'b1);
        run_window(1);
        sw_rst_req = 1'b0;
        run_window(45);
        check("t3_pending", 32'(exp_q.size()), 32'h0);

        // 4: request held through HOLD/RELEASE is ignored, accepted on first RUN edge
        async_reset();
        sw_rst_req = 1'b1;
        run_window(2);
        release_rst();
        push_seq(base, 18, 1'b0, 4, 1'b0);
        push_ev(base + 43, 7'b11_0_0000);
        push_ev(base + 44, 7'b01_0_0000);
        push_seq(base + 43, 16, 1'b1, 4, 1'b1);
        run_window(43);
        sw_rst_req = 1'b0;
        run_window(45);
        check("t4_pending", 32'(exp_q.size()), 32'h0);

        // 5: single stage, minimal hold and spacing
        @(negedge clk);
        rst1 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("s1_bit0", 32'(rst_out_n1), 32'(e >= 3));
            check("s1_ready", 32'(ready1), 32'(e >= 4));
            check("s1_ack", 32'(sw_rst_ack1), 32'h0);
        end

        // 6: rst deasserted at random phase relative to clk
        for (int r = 0; r < 100; r++) begin
            async_reset();
            @(posedge clk);
            d = int'($urandom_range(1, 9));
            #(d);
            rst  = 1'b0;
            base = cyc;
            push_seq(base, 18, 1'b0, 4, 1'b1);
            run_window(44);
            check("t6_pending", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
